mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage 4 of the five-stage MIPS core. It sits between EX and WB.
- It registers the EX-to-MEM bus and finishes loads by aligning and extending the data SRAM read data (lb/lbu/lh/lhu/lw). It selects the writeback value, drives the MEM forwarding and HI/LO buses, and passes everything to WB.
- The data SRAM response carries a valid handshake. A small FSM stalls the pipeline until load data arrives and holds that data while the stage is frozen.

Parameters:
- DATA_W, 32, datapath and SRAM data width.
- (Bus widths come from shared defines: EX_TO_MEM_WD=150, MEM_TO_WB_WD=136, MEM_TO_RF_WD=38, StallBus=6.)

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- stall  in  StallBus  pipeline stall vector; bit 3 = MEM, bit 4 = WB; Stop=1.
- ex_to_mem_bus  in  150  {hilo_bus[65:0], mem_op[7:0], pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}, MSB first.
- data_sram_rdata  in  32  SRAM read data.
- data_sram_rvalid  in  1  SRAM read data valid this cycle.
- mem_to_wb_bus  out  136  {hilo_bus[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- mem_to_rf_bus  out  38  forwarding bus {rf_we, rf_waddr, rf_wdata}.
- mem_hilo_bus  out  66  {hi_we, lo_we, hi[31:0], lo[31:0]}, forwarded to ID/EX.
- stallreq_for_mem  out  1  stall request to the stall controller.

Behaviour:
- Input register, updated on clk:
  - rst: clear to 0.
  - else if stall[3]=Stop and stall[4]=NoStop: clear to 0 (bubble).
  - else if stall[3]=NoStop: load ex_to_mem_bus.
  - else: hold.
- Reset values: all outputs 0, FSM in IDLE, hold-data register 0.
- mem_op bit order, [7:0]: lb, lbu, lh, lhu, lw, sb, sh, sw.
- is_load = data_ram_en & (data_ram_wen==0) & (lb|lbu|lh|lhu|lw).
- SRAM timing: the request is issued in EX at cycle N. Data is earliest valid in MEM at cycle N+1, together with rvalid.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, is_load & !rvalid: stallreq=1, go to WAIT.
  - IDLE, is_load & rvalid: use rdata directly. If stall[3]=Stop, capture rdata into hold_q and go to HOLD.
  - WAIT: stallreq=1 while !rvalid. On rvalid, stallreq=0 in the same cycle (combinational) and use rdata. Go to HOLD (capture) if stall[3]=Stop, else go to IDLE.
  - HOLD: stallreq=0 and use hold_q. Leave for IDLE on the first cycle with stall[3]=NoStop.
  - rvalid is ignored in HOLD and for non-loads.
- Load alignment, a = ex_result[1:0]:
  - byte = rdata[8a+7:8a]; half = a[1] ? rdata[31:16] : rdata[15:0].
  - lb: sign-extend byte. lbu: zero-extend byte.
  - lh: sign-extend half. lhu: zero-extend half.
  - lw: full word.
- rf_wdata = sel_rf_res ? load_data : ex_result.
- Stores: MEM does no SRAM action (EX issues them); they pass through with rf_we as registered.
- Outputs are combinational from the register, FSM state and rdata. hilo_bus and pc pass through unchanged.
- Forwarding bus while stallreq=1: rf_we is forced to 0 so no stale load data is forwarded. mem_to_wb_bus is unaffected, because stall[4] freezes WB consumption.
- Reset mid-WAIT: synchronous rst returns the FSM to IDLE and drops stallreq in the next cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port mem_addr_err (1 bit).
  - mem_addr_err=1 for lh/lhu with a[0]=1, or lw with a!=0.
  - When set, rf_we is forced to 0 on both output buses, and the FSM stays in IDLE with no stall.
- Undefined: no port; misaligned accesses use the alignment rules above unchecked.

Decomposition:
- Shared defines header: EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_RF_WD, Stop/NoStop, mem_op bit positions, FSM state encodings.
- One sub-module: load_align (combinational: rdata, addr[1:0], mem_op → load_data), so WB or a future cache can reuse it.

Test Plan:
- lb at addr 0x...03, rdata 0x80FF_1234, rvalid=1 at N+1 → rf_wdata 0xFFFF_FF80, stallreq 0, no extra cycles.
- lhu at addr 0x...02, rdata 0x8001_0000 → 0x0000_8001; lh at the same address → 0xFFFF_8001.
- lw with rvalid delayed 3 cycles → stallreq=1 for exactly 3 cycles; mem_to_rf rf_we=0 meanwhile; rf_wdata = rdata of the rvalid cycle.
- lw with rvalid in IDLE while stall[3]=Stop for 2 more cycles, rdata changing after the rvalid cycle → HOLD keeps the captured value; stallreq stays 0.
- stall[3]=Stop, stall[4]=NoStop → next output bus all zero (bubble). rst asserted during WAIT → stallreq 0 and outputs 0 the next cycle.
- Non-load (addu result 0x1234, sel_rf_res=0, hi_we=1) → rf_wdata 0x1234, hilo bus unchanged. With MEM_ALIGN_CHECK_EN: lw at 0x...01 → mem_addr_err=1, rf_we=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_pkg : shared bus widths, stall/mem_op encodings, FSM states      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 150;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_RF_WD = 38;
  localparam int STALL_BUS_W  = 6;
  localparam int HILO_WD      = 66;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [HILO_WD-1:0] hilo;
    logic [7:0]         mem_op;
    logic [31:0]        pc;
    logic               data_ram_en;
    logic [3:0]         data_ram_wen;
    logic               sel_rf_res;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        ex_result;
  } ex_to_mem_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_align : byte/half/word select and sign/zero extension of load data    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic [7:0]        mem_op_i,
  output logic [DATA_W-1:0] load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused_store_ops;

  assign w_byte = rdata_i[{addr_i, 3'b000} +: 8];
  assign w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign w_unused_store_ops = ^mem_op_i[OP_SB:OP_SW];

  always_comb begin
    load_data_o = rdata_i;
    if (mem_op_i[OP_LB])
      load_data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
    else if (mem_op_i[OP_LBU])
      load_data_o = {{(DATA_W-8){1'b0}}, w_byte};
    else if (mem_op_i[OP_LH])
      load_data_o = {{(DATA_W-16){w_half[15]}}, w_half};
    else if (mem_op_i[OP_LHU])
      load_data_o = {{(DATA_W-16){1'b0}}, w_half};
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : MIPS pipeline stage 4 - load completion, writeback select,     |
// |             forwarding. Optional MEM_ALIGN_CHECK_EN adds mem_addr_err.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_W-1:0]  stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [DATA_W-1:0]       data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic [HILO_WD-1:0]      mem_hilo_bus,
  output logic                    stallreq_for_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                    mem_addr_err
`endif
);

  ex_to_mem_t  bus_q;
  mem_state_e  state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              w_mem_stop;
  logic              w_is_load;
  logic              w_addr_err;
  logic              w_load_go;
  logic              w_stallreq;
  logic              w_use_hold;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_wb_we;
  logic              w_fwd_we;

  assign w_mem_stop = (stall[STALL_MEM] == STOP);

  always_ff @(posedge clk) begin
    if (rst)
      bus_q <= '0;
    else if (w_mem_stop && stall[STALL_WB] == NO_STOP)
      bus_q <= '0;
    else if (!w_mem_stop)
      bus_q <= ex_to_mem_bus;
  end

  assign w_is_load = bus_q.data_ram_en && (bus_q.data_ram_wen == 4'd0)
                     && (|bus_q.mem_op[OP_LB:OP_LW]);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_addr_err = ((bus_q.mem_op[OP_LH] | bus_q.mem_op[OP_LHU]) & bus_q.ex_result[0])
                      | (bus_q.mem_op[OP_LW] & (bus_q.ex_result[1:0] != 2'd0));
  assign mem_addr_err = w_addr_err;
`else
  assign w_addr_err = 1'b0;
`endif

  // A misaligned access never waits for the SRAM, so it cannot stall the pipe.
  assign w_load_go = w_is_load & ~w_addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    w_stallreq = 1'b0;
    w_use_hold = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_load_go) begin
          if (!data_sram_rvalid) begin
            w_stallreq = 1'b1;
            state_d    = ST_WAIT;
          end else if (w_mem_stop) begin
            hold_d  = data_sram_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (!data_sram_rvalid) begin
          w_stallreq = 1'b1;
        end else if (w_mem_stop) begin
          hold_d  = data_sram_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_use_hold = 1'b1;
        if (!w_mem_stop)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_raw = w_use_hold ? hold_q : data_sram_rdata;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata_i     (w_raw),
    .addr_i      (bus_q.ex_result[1:0]),
    .mem_op_i    (bus_q.mem_op),
    .load_data_o (w_load_data)
  );

  assign w_rf_wdata = bus_q.sel_rf_res ? w_load_data : bus_q.ex_result;
  assign w_wb_we    = bus_q.rf_we & ~w_addr_err;
  // Forwarding must not expose rdata that has not yet been validated.
  assign w_fwd_we   = w_wb_we & ~w_stallreq;

  assign mem_to_wb_bus    = {bus_q.hilo, bus_q.pc, w_wb_we, bus_q.rf_waddr, w_rf_wdata};
  assign mem_to_rf_bus    = {w_fwd_we, bus_q.rf_waddr, w_rf_wdata};
  assign mem_hilo_bus     = bus_q.hilo;
  assign stallreq_for_mem = w_stallreq;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage : instruction-level reference model, directed + random load   |
// | traffic with a responding SRAM and stall controller.                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [149:0] ex_bus;
  logic [31:0]  rdata;
  logic         rvalid;
  logic [135:0] wb_bus;
  logic [37:0]  rf_bus;
  logic [65:0]  hilo_o;
  logic         stallreq;
`ifdef MEM_ALIGN_CHECK_EN
  logic         addr_err_o;
`endif

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .mem_to_wb_bus    (wb_bus),
    .mem_to_rf_bus    (rf_bus),
    .mem_hilo_bus     (hilo_o),
    .stallreq_for_mem (stallreq)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_addr_err     (addr_err_o)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [149:0] mk(input logic [65:0] hilo, input logic [7:0] op,
                                      input logic [31:0] pc, input logic en,
                                      input logic [3:0] wen, input logic sel, input logic we,
                                      input logic [4:0] waddr, input logic [31:0] res);
    return {hilo, op, pc, en, wen, sel, we, waddr, res};
  endfunction

  // Model: the instruction currently in MEM, and whether its load data is already captured.
  logic [149:0] m_bus  = '0;
  bit           m_have = 1'b0;
  logic [31:0]  m_data = '0;

  function automatic bit f_aerr(input logic [149:0] b);
`ifdef MEM_ALIGN_CHECK_EN
    logic [7:0] op;
    logic [1:0] a;
    op = b[83:76];
    a  = b[1:0];
    return ((op[5] || op[4]) && a[0]) || (op[3] && a != 2'd0);
`else
    return (b[0] & 1'b0);
`endif
  endfunction

  function automatic bit f_load(input logic [149:0] b);
    return b[43] && (b[42:39] == 4'd0) && (b[83:79] != 5'd0) && !f_aerr(b);
  endfunction

  function automatic bit f_stall(input logic rv);
    return f_load(m_bus) && !m_have && !rv;
  endfunction

  function automatic logic [31:0] f_align(input logic [7:0] op, input logic [1:0] a,
                                          input logic [31:0] raw);
    logic [31:0] byt, half;
    byt  = (raw >> (8 * a)) & 32'hFF;
    half = a[1] ? (raw >> 16) : (raw & 32'hFFFF);
    if (op[7]) return (byt >= 128) ? byt + 32'hFFFF_FF00 : byt;
    if (op[6]) return byt;
    if (op[5]) return (half >= 32768) ? half + 32'hFFFF_0000 : half;
    if (op[4]) return half;
    return raw;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_bus  <= '0;
      m_have <= 1'b0;
      m_data <= '0;
    end else begin
      if (f_load(m_bus) && !m_have && rvalid && stall[3]) begin
        m_have <= 1'b1;
        m_data <= rdata;
      end
      if (stall[3] && !stall[4]) begin
        m_bus  <= '0;
        m_have <= 1'b0;
      end else if (!stall[3]) begin
        m_bus  <= ex_bus;
        m_have <= 1'b0;
      end
    end
  end

  task automatic compare();
    logic [31:0] raw, wd;
    bit st, we_wb, aerr;
    st    = f_stall(rvalid);
    aerr  = f_aerr(m_bus);
    raw   = m_have ? m_data : rdata;
    wd    = m_bus[38] ? f_align(m_bus[83:76], m_bus[1:0], raw) : m_bus[31:0];
    we_wb = m_bus[37] && !aerr;
    chk("stallreq", stallreq, st);
    chk("wb_ctrl", wb_bus[135:32], {m_bus[149:84], m_bus[75:44], we_wb, m_bus[36:32]});
    chk("rf_ctrl", rf_bus[37:32], {we_wb && !st, m_bus[36:32]});
    chk("hilo_bus", hilo_o, m_bus[149:84]);
    if (!(m_bus[38] && st)) begin
      chk("wb_wdata", wb_bus[31:0], wd);
      chk("rf_wdata", rf_bus[31:0], wd);
    end
`ifdef MEM_ALIGN_CHECK_EN
    chk("addr_err", addr_err_o, aerr);
`endif
  endtask

  always begin
    @(negedge clk);
    #2;
    if (armed) compare();
  end

  task automatic cyc(input bit r, input logic [5:0] s, input logic [149:0] b,
                     input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst    = r;
    stall  = s;
    ex_bus = b;
    rvalid = rv;
    rdata  = rd;
  endtask

  function automatic logic [149:0] gen();
    logic [65:0] hilo;
    logic [7:0]  op;
    logic [3:0]  wen;
    logic        en, sel, we;
    int          k;
    hilo = {$urandom, $urandom, $urandom};
    k    = int'($urandom % 4);
    op   = 8'h00; en = 1'b0; wen = 4'd0; sel = 1'b0; we = 1'($urandom);
    case (k)
      0: begin op = 8'h80 >> ($urandom % 5); en = 1'b1; sel = 1'b1; we = 1'b1; end
      1: begin op = 8'h04 >> ($urandom % 3); en = 1'b1; wen = 4'($urandom_range(1, 15)); we = 1'b0; end
      3: op = 8'h80 >> ($urandom % 5);
      default: ;
    endcase
    return mk(hilo, op, $urandom, en, wen, sel, we, 5'($urandom), $urandom);
  endfunction

  localparam logic [5:0] S_RUN = 6'b000000;
  localparam logic [5:0] S_ALL = 6'b011111;
  localparam logic [5:0] S_BUB = 6'b001111;

  logic [149:0] NOP, LB, LHU, LH, LW, LW2, ALU;
  int           delay;
  bit           pend, rv_r;
  int           sel_r;
  logic [5:0]   s_r;
  bit           rst_r;

  initial begin
    NOP = '0;
    LB  = mk(66'd0, 8'h80, 32'h100, 1'b1, 4'd0, 1'b1, 1'b1, 5'd5, 32'h0000_1003);
    LHU = mk(66'd0, 8'h10, 32'h104, 1'b1, 4'd0, 1'b1, 1'b1, 5'd6, 32'h0000_2002);
    LH  = mk(66'd0, 8'h20, 32'h108, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, 32'h0000_2002);
    LW  = mk(66'd0, 8'h08, 32'h10C, 1'b1, 4'd0, 1'b1, 1'b1, 5'd8, 32'h0000_3000);
    LW2 = mk(66'd0, 8'h08, 32'h110, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0000_4000);
    ALU = mk({1'b1, 1'b0, 32'hAAAA_5555, 32'h0}, 8'h00, 32'h200, 1'b0, 4'd0, 1'b0, 1'b1,
             5'd3, 32'h0000_1234);

    rst = 1'b1; stall = S_RUN; ex_bus = '0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    armed = 1'b1;

    cyc(0, S_RUN, NOP, 0, 0); #3;
    chk("reset_wb_bus", wb_bus, 136'd0);
    chk("reset_rf_bus", rf_bus, 38'd0);
    chk("reset_stallreq", stallreq, 1'b0);

    cyc(0, S_RUN, LB, 0, 0);
    cyc(0, S_RUN, LHU, 1, 32'h80FF_1234); #3;
    chk("lb_wdata", wb_bus[31:0], 32'hFFFF_FF80);
    chk("lb_stallreq", stallreq, 1'b0);
    cyc(0, S_RUN, LH, 1, 32'h8001_0000); #3;
    chk("lhu_wdata", wb_bus[31:0], 32'h0000_8001);
    cyc(0, S_RUN, LW, 1, 32'h8001_0000); #3;
    chk("lh_wdata", wb_bus[31:0], 32'hFFFF_8001);

    for (int i = 0; i < 3; i++) begin
      cyc(0, S_ALL, NOP, 0, $urandom); #3;
      chk("lw_wait_stallreq", stallreq, 1'b1);
      chk("lw_wait_fwd_we", rf_bus[37], 1'b0);
    end
    cyc(0, S_RUN, LW2, 1, 32'hCAFE_F00D); #3;
    chk("lw_late_wdata", wb_bus[31:0], 32'hCAFE_F00D);
    chk("lw_late_stallreq", stallreq, 1'b0);

    cyc(0, S_ALL, NOP, 1, 32'h1111_2222); #3;
    chk("hold_first", wb_bus[31:0], 32'h1111_2222);
    cyc(0, S_ALL, NOP, 1, 32'h3333_4444); #3;
    chk("hold_keep1", wb_bus[31:0], 32'h1111_2222);
    cyc(0, S_ALL, NOP, 0, 32'h5555_6666); #3;
    chk("hold_keep2", wb_bus[31:0], 32'h1111_2222);
    chk("hold_stallreq", stallreq, 1'b0);
    cyc(0, S_RUN, ALU, 0, 32'h7777_8888); #3;
    chk("hold_release", wb_bus[31:0], 32'h1111_2222);

    cyc(0, S_BUB, NOP, 0, 0); #3;
    chk("alu_wdata", wb_bus[31:0], 32'h0000_1234);
    chk("alu_hilo", hilo_o, {1'b1, 1'b0, 32'hAAAA_5555, 32'h0});
    cyc(0, S_RUN, LW, 0, 0); #3;
    chk("bubble_wb_bus", wb_bus, 136'd0);
    chk("bubble_rf_bus", rf_bus, 38'd0);

    cyc(0, S_ALL, NOP, 0, 0); #3;
    chk("rstwait_stallreq", stallreq, 1'b1);
    cyc(1, S_ALL, NOP, 0, 0);
    cyc(0, S_RUN, NOP, 0, 0); #3;
    chk("rstwait_after_stallreq", stallreq, 1'b0);
    chk("rstwait_after_wb_bus", wb_bus, 136'd0);

`ifdef MEM_ALIGN_CHECK_EN
    cyc(0, S_RUN, mk(66'd0, 8'h08, 32'h300, 1'b1, 4'd0, 1'b1, 1'b1, 5'd4, 32'h0000_5001), 0, 0);
    cyc(0, S_RUN, NOP, 0, 0); #3;
    chk("misalign_err", addr_err_o, 1'b1);
    chk("misalign_wb_we", wb_bus[37], 1'b0);
    chk("misalign_rf_we", rf_bus[37], 1'b0);
    chk("misalign_stallreq", stallreq, 1'b0);
`endif

    delay = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      pend = f_load(m_bus) && !m_have;
      if (pend) begin
        rv_r = (delay == 0);
        if (delay > 0) delay--;
      end else begin
        rv_r = ($urandom % 4) == 0;
      end
      if (f_stall(rv_r)) begin
        s_r = S_ALL;
      end else begin
        sel_r = int'($urandom % 4);
        s_r   = (sel_r == 2) ? S_ALL : (sel_r == 3) ? S_BUB : S_RUN;
      end
      rst_r  = ($urandom % 97) == 0;
      rst    = rst_r;
      stall  = s_r;
      rvalid = rv_r;
      rdata  = $urandom;
      ex_bus = gen();
      if (!s_r[3] && !rst_r) delay = int'($urandom % 4);
    end

    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
